// File: rtl/key_pkg.sv
// Shared definitions for the push-button debouncer: channel state
// encoding, board clock rate and time-to-cycle helpers.
package key_pkg;

  // Per-channel debounce state.
  typedef enum logic [1:0] {
    UP       = 2'd0,
    DEB_DOWN = 2'd1,
    DOWN     = 2'd2,
    DEB_UP   = 2'd3
  } key_fsm_e;

  // Board oscillator feeding CLOCK_50.
  localparam int CLK_HZ = 50000000;

  // Convert a duration in milliseconds to CLOCK_50 cycles.
  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  // Larger of two integers, used to size the shared hold/repeat counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One push-button channel: 2-flop synchronizer, debounce FSM with its
// qualification counter, and the hold counter that drives auto-repeat.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_state,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_MAX = max_int(HOLD_CYCLES, REPEAT_CYCLES);
  localparam int HOLD_W   = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;

  localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = '0;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             w_pressed;
  key_fsm_e         r_fsm;
  logic [CNT_W-1:0] r_cnt;
  logic [HOLD_W-1:0] r_hold;
  logic             r_rep_phase;
  logic             w_hold_term;

  // Bring the asynchronous, active-low pin into the clock domain; reset
  // value 1 means "released" so nothing looks pressed coming out of reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = ~r_sync2;

  // First repeat waits the long hold time, later ones the short period.
  assign w_hold_term = (r_hold == (r_rep_phase ? REP_LAST : HOLD_LAST));

  // Debounce FSM with registered level/strobe outputs and the hold counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fsm       <= UP;
      r_cnt       <= CNT_ZERO;
      r_hold      <= HOLD_ZERO;
      r_rep_phase <= 1'b0;
      o_state     <= 1'b0;
      o_press     <= 1'b0;
      o_release   <= 1'b0;
      o_repeat    <= 1'b0;
    end else begin
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_repeat  <= 1'b0;
      case (r_fsm)
        UP: begin
          r_hold      <= HOLD_ZERO;
          r_rep_phase <= 1'b0;
          if (w_pressed) begin
            r_fsm <= DEB_DOWN;
            r_cnt <= CNT_ONE;
          end
        end
        DEB_DOWN: begin
          if (!w_pressed) begin
            // Bounce: throw away all qualification progress.
            r_fsm <= UP;
            r_cnt <= CNT_ZERO;
          end else if (r_cnt == DEB_LAST) begin
            r_fsm       <= DOWN;
            r_cnt       <= CNT_ZERO;
            r_hold      <= HOLD_ZERO;
            r_rep_phase <= 1'b0;
            o_state     <= 1'b1;
            o_press     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DOWN: begin
          if (w_hold_term) begin
            r_hold      <= HOLD_ZERO;
            r_rep_phase <= 1'b1;
            o_repeat    <= 1'b1;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
          if (!w_pressed) begin
            r_fsm <= DEB_UP;
            r_cnt <= CNT_ONE;
          end
        end
        DEB_UP: begin
          if (!w_pressed && (r_cnt == DEB_LAST)) begin
            // Release takes priority over a repeat due on the same edge.
            r_fsm       <= UP;
            r_cnt       <= CNT_ZERO;
            r_hold      <= HOLD_ZERO;
            r_rep_phase <= 1'b0;
            o_state     <= 1'b0;
            o_release   <= 1'b1;
          end else begin
            // Still held (or still qualifying the release): keep repeating.
            if (w_hold_term) begin
              r_hold      <= HOLD_ZERO;
              r_rep_phase <= 1'b1;
              o_repeat    <= 1'b1;
            end else begin
              r_hold <= r_hold + 1'b1;
            end
            if (w_pressed) begin
              // Glitch on a held key: back to DOWN, hold schedule preserved.
              r_fsm <= DOWN;
              r_cnt <= CNT_ZERO;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_fsm <= UP;
          r_cnt <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debouncer.sv
// Board push-button front end: one independent debounce/auto-repeat
// channel per KEY pin, outputs concatenated into per-key bit vectors.
module key_debouncer
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = ms_to_cycles(20),
  parameter int HOLD_CYCLES     = ms_to_cycles(500),
  parameter int REPEAT_CYCLES   = ms_to_cycles(100)
) (
  input  logic                CLOCK_50,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat
);

  // One identical channel per button.
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .i_clk     (CLOCK_50),
      .i_rst     (rst),
      .i_key_n   (KEY[g]),
      .o_state   (key_state[g]),
      .o_press   (key_press[g]),
      .o_release (key_release[g]),
      .o_repeat  (key_repeat[g])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench for key_debouncer: a time-based reference model pushes
// the expected outputs for every clock edge, a monitor pops and compares.
module tb_key_debouncer;

  localparam int NK = 4;
  localparam int D  = 8;
  localparam int H  = 40;
  localparam int R  = 10;

  logic          clk;
  logic          rst;
  logic [NK-1:0] KEY;
  logic [NK-1:0] key_state, key_press, key_release, key_repeat;

  key_debouncer #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (R)
  ) dut (
    .CLOCK_50    (clk),
    .rst         (rst),
    .KEY         (KEY),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_release (key_release),
    .key_repeat  (key_repeat)
  );

  typedef struct packed {
    logic [NK-1:0] st;
    logic [NK-1:0] pr;
    logic [NK-1:0] rl;
    logic [NK-1:0] rp;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Observed event history (from DUT outputs, for directed checks)
  int press_cyc[NK];
  int press_cnt[NK];
  int rel_cnt[NK];
  int rep_cnt[NK];
  int rep_last[NK];

  // Reference model state: timing expressed as "how long has the
  // synchronized level been steady" and "how long since the press".
  logic [NK-1:0] m_s1, m_s2, m_sprev, m_acc;
  int            m_run[NK];
  int            m_t[NK];

  task automatic chk_vec(input string nm, input logic [NK-1:0] act, input logic [NK-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, req);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Reference model: evaluated on every rising edge from the inputs.
  initial begin
    forever begin
      logic [NK-1:0] s, pr, rl, rp;
      @(posedge clk);
      cyc++;
      pr = '0; rl = '0; rp = '0;
      if (rst) begin
        m_s1 = '1; m_s2 = '1; m_sprev = '0; m_acc = '0;
        for (int k = 0; k < NK; k++) begin
          m_run[k] = 0;
          m_t[k]   = 0;
        end
      end else begin
        s    = ~m_s2;
        m_s2 = m_s1;
        m_s1 = KEY;
        for (int k = 0; k < NK; k++) begin
          if (s[k] == m_sprev[k]) begin
            if (m_run[k] < 1000) m_run[k]++;
          end else begin
            m_run[k] = 1;
          end
          m_sprev[k] = s[k];
          if (!m_acc[k]) begin
            if (s[k] && m_run[k] == D) begin
              m_acc[k] = 1'b1;
              pr[k]    = 1'b1;
              m_t[k]   = 0;
            end
          end else begin
            m_t[k]++;
            if (!s[k] && m_run[k] == D) begin
              m_acc[k] = 1'b0;
              rl[k]    = 1'b1;
            end else if (m_t[k] == H || (m_t[k] > H && (m_t[k] - H) % R == 0)) begin
              rp[k] = 1'b1;
            end
          end
        end
      end
      exp_q.push_back({m_acc, pr, rl, rp});
    end
  end

  // Monitor: compare DUT outputs against the queued expectation.
  initial begin
    for (int k = 0; k < NK; k++) begin
      press_cyc[k] = -1; press_cnt[k] = 0; rel_cnt[k] = 0;
      rep_cnt[k] = 0; rep_last[k] = -1;
    end
    forever begin
      exp_t e;
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_vec("key_state",   key_state,   e.st);
        chk_vec("key_press",   key_press,   e.pr);
        chk_vec("key_release", key_release, e.rl);
        chk_vec("key_repeat",  key_repeat,  e.rp);
        for (int k = 0; k < NK; k++) begin
          if (key_press[k] === 1'b1) begin press_cyc[k] = cyc; press_cnt[k]++; end
          if (key_release[k] === 1'b1) rel_cnt[k]++;
          if (key_repeat[k] === 1'b1) begin rep_cnt[k]++; rep_last[k] = cyc; end
        end
      end
    end
  end

  // Stimulus
  initial begin
    int t0, b0, b1, p2;
    int dur[NK];
    rst = 1'b1;
    KEY = 4'b0000;
    tick(3);

    // Reset release with all keys already held down
    rst = 1'b0;
    t0  = cyc;
    tick(15);
    for (int k = 0; k < NK; k++) chk_int("reset_press_latency", press_cyc[k] - t0, 10);
    KEY = 4'b1111;
    tick(15);

    // Clean press on key 0
    KEY[0] = 1'b0;
    t0 = cyc;
    tick(15);
    chk_int("clean_press_latency_k0", press_cyc[0] - t0, 10);
    KEY[0] = 1'b1;
    tick(15);

    // Bounce rejection on key 1
    b0 = press_cnt[1];
    KEY[1] = 1'b0; tick(5);
    KEY[1] = 1'b1; tick(2);
    KEY[1] = 1'b0;
    t0 = cyc;
    tick(15);
    chk_int("bounce_press_count_k1", press_cnt[1] - b0, 1);
    chk_int("bounce_press_latency_k1", press_cyc[1] - t0, 10);
    KEY[1] = 1'b1;
    tick(15);

    // Auto-repeat on key 2; release timed so the final repeat meets the release
    b0 = rep_cnt[2];
    b1 = rel_cnt[2];
    KEY[2] = 1'b0;
    tick(10);
    tick(100);
    KEY[2] = 1'b1;
    tick(20);
    p2 = press_cyc[2];
    chk_int("repeat_count_k2", rep_cnt[2] - b0, 7);
    chk_int("repeat_last_k2", rep_last[2] - p2, 100);
    chk_int("repeat_release_k2", rel_cnt[2] - b1, 1);

    // Release glitch on held key 3
    b0 = rep_cnt[3];
    b1 = rel_cnt[3];
    KEY[3] = 1'b0;
    tick(10);
    tick(20);
    KEY[3] = 1'b1; tick(3);
    KEY[3] = 1'b0;
    tick(40);
    chk_int("glitch_no_release_k3", rel_cnt[3] - b1, 0);
    chk_int("glitch_repeat_count_k3", rep_cnt[3] - b0, 3);
    KEY[3] = 1'b1;
    tick(20);

    // Simultaneous press on keys 0 and 1, then reset during release debounce
    KEY[1:0] = 2'b00;
    t0 = cyc;
    tick(12);
    chk_int("simul_press_same_cycle", press_cyc[1] - press_cyc[0], 0);
    chk_int("simul_press_latency", press_cyc[0] - t0, 10);
    b0 = rel_cnt[0];
    b1 = rel_cnt[1];
    KEY[1:0] = 2'b11;
    tick(5);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(20);
    chk_int("midreset_no_release_k0", rel_cnt[0] - b0, 0);
    chk_int("midreset_no_release_k1", rel_cnt[1] - b1, 0);

    // Randomized bouncing on all keys with occasional resets
    for (int k = 0; k < NK; k++) dur[k] = 0;
    for (int i = 0; i < 2500; i++) begin
      for (int k = 0; k < NK; k++) begin
        if (dur[k] == 0) begin
          KEY[k] = 1'($urandom_range(0, 1));
          dur[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 80))
                                               : int'($urandom_range(1, 12));
        end else begin
          dur[k]--;
        end
      end
      rst = ($urandom_range(0, 599) == 0);
      tick(1);
    end
    rst = 1'b0;
    KEY = 4'b1111;
    tick(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
